// File: rtl/io_channel_unit_if.sv
// io_channel_unit_if: output stream of the I/O channel unit.
// The master drives the head entry of the output FIFO; the slave consumes it.
interface io_channel_unit_if;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sel;
  logic [14:0] out_data;

  modport master (
    output out_valid,
    output out_sel,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_sel,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/io_channel_unit.sv
// io_channel_unit: eight 15-bit I/O channel registers.
//   - The core reads channels through IO_read_sel.
//   - The core writes channels through IO_write_*; every core write is also
//     queued in an output FIFO that drains over a valid/ready stream.
//   - Peripherals load channels through the ext_in_* strobe port.
//     These loads never enter the FIFO.
// Optional macro IO_CHANNEL_BYPASS_EN: forwards a same-cycle core write to
// IO_read_data when the write and read channels match. Without it, the read
// always returns the registered channel value.
module io_channel_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               IO_write_en,
  input  logic [2:0]         IO_write_sel,
  input  logic [14:0]        IO_write_data,
  input  logic [2:0]         IO_read_sel,
  output logic [14:0]        IO_read_data,
  input  logic               ext_in_valid,
  input  logic [2:0]         ext_in_sel,
  input  logic [14:0]        ext_in_data,
  io_channel_unit_if.master  out_if,
  output logic               overflow,
  input  logic               overflow_clr
);

  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W:0] PTR_ONE = 1;

  logic [14:0]    ch_q [8];
  logic [17:0]    fifo_q [FIFO_DEPTH];
  logic [IDX_W:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
  logic           overflow_q, overflow_d;

  logic             empty, full, pop, push, drop;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [17:0]      head;
  logic [14:0]      read_data;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign pop    = !empty && out_if.out_ready;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts the write and occupancy stays the same.
  assign push   = IO_write_en && (!full || pop);
  assign drop   = IO_write_en && full && !pop;
  assign head   = fifo_q[rd_idx];

  assign out_if.out_valid = !empty;
  assign out_if.out_sel   = empty ? 3'd0  : head[17:15];
  assign out_if.out_data  = empty ? 15'd0 : head[14:0];
  assign overflow         = overflow_q;

  // Next-state logic for the FIFO pointers and the sticky overflow flag.
  // A drop takes priority over a clear in the same cycle.
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  // Register the pointers and the overflow flag.
  // Reset discards any queued entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Store each accepted core write as {channel, data} at the write index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_idx] <= {IO_write_sel, IO_write_data};
    end
  end

  // Update the channel registers. When the core and a peripheral target the
  // same channel in one cycle, the core write wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) ch_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (IO_write_en && (IO_write_sel == 3'(i)))
          ch_q[i] <= IO_write_data;
        else if (ext_in_valid && (ext_in_sel == 3'(i)))
          ch_q[i] <= ext_in_data;
      end
    end
  end

  // Select the channel read by the core.
  // Optionally forward a same-cycle core write to the read port.
  always_comb begin
    read_data = ch_q[IO_read_sel];
`ifdef IO_CHANNEL_BYPASS_EN
    if (reset_n && IO_write_en && (IO_write_sel == IO_read_sel))
      read_data = IO_write_data;
`else
    read_data = ch_q[IO_read_sel];
`endif
  end

  assign IO_read_data = read_data;

endmodule

// File: tb/tb_io_channel_unit.sv
// tb_io_channel_unit: directed scoreboard bench for io_channel_unit.
// Each accepted core write queues its expected {channel, data}. A negedge
// monitor pops the queue on every valid/ready transfer and compares.
// Compile with or without IO_CHANNEL_BYPASS_EN; the bypass expectation
// follows the same macro.
module tb_io_channel_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        IO_write_en = 1'b0;
  logic [2:0]  IO_write_sel = '0;
  logic [14:0] IO_write_data = '0;
  logic [2:0]  IO_read_sel = '0;
  logic [14:0] IO_read_data;
  logic        ext_in_valid = 1'b0;
  logic [2:0]  ext_in_sel = '0;
  logic [14:0] ext_in_data = '0;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int assertCount = 0;
  int failCount = 0;
  logic [17:0] sbQueue [$];

  io_channel_unit_if outIf ();

  io_channel_unit #(.FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .IO_write_en   (IO_write_en),
    .IO_write_sel  (IO_write_sel),
    .IO_write_data (IO_write_data),
    .IO_read_sel   (IO_read_sel),
    .IO_read_data  (IO_read_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_sel    (ext_in_sel),
    .ext_in_data   (ext_in_data),
    .out_if        (outIf),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  // Compare an observed value with the expected one and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of core write and/or peripheral load.
  // If the write should enter the FIFO, record it in the scoreboard.
  task automatic applyStimulus(input logic we, input logic [2:0] wsel, input logic [14:0] wdata,
                               input logic ev, input logic [2:0] esel, input logic [14:0] edata,
                               input logic expectPush);
    IO_write_en   = we;
    IO_write_sel  = wsel;
    IO_write_data = wdata;
    ext_in_valid  = ev;
    ext_in_sel    = esel;
    ext_in_data   = edata;
    if (expectPush) sbQueue.push_back({wsel, wdata});
    tick();
    IO_write_en  = 1'b0;
    ext_in_valid = 1'b0;
  endtask

  // Hold out_ready high until the scoreboard empties, within a cycle budget.
  task automatic drainAll(input string tag, input int maxCycles);
    int n = 0;
    outIf.out_ready = 1'b1;
    while (sbQueue.size() != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput({tag, "_drained"}, sbQueue.size(), 0);
    checkOutput({tag, "_emptyValid"}, outIf.out_valid, 1'b0);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && outIf.out_valid && outIf.out_ready) begin
      if (sbQueue.size() == 0)
        checkOutput("unexpectedEntry", sbQueue.size(), 1);
      else
        checkOutput("fifoHead", {outIf.out_sel, outIf.out_data}, sbQueue.pop_front());
    end
  end

  initial begin
    outIf.out_ready = 1'b0;

    // Outputs while reset is held at power-up.
    #3;
    checkOutput("resetValid", outIf.out_valid, 1'b0);
    checkOutput("resetReadData", IO_read_data, 15'd0);
    checkOutput("resetOverflow", overflow, 1'b0);
    #9 reset_n = 1'b1;
    tick();

    // Queue two entries, then reset in the middle of operation.
    applyStimulus(1'b1, 3'd0, 15'd1, 1'b0, 3'd0, 15'd0, 1'b1);
    applyStimulus(1'b1, 3'd1, 15'd2, 1'b0, 3'd0, 15'd0, 1'b1);
    checkOutput("queuedValid", outIf.out_valid, 1'b1);
    reset_n = 1'b0;
    sbQueue.delete();
    #1;
    checkOutput("midResetValid", outIf.out_valid, 1'b0);
    checkOutput("midResetSel", outIf.out_sel, 3'd0);
    checkOutput("midResetData", outIf.out_data, 15'd0);
    #2 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      IO_read_sel = 3'(i);
      #1;
      checkOutput("postResetChannel", IO_read_data, 15'd0);
    end
    checkOutput("postResetOverflow", overflow, 1'b0);
    checkOutput("postResetValid", outIf.out_valid, 1'b0);
    outIf.out_ready = 1'b1;
    applyStimulus(1'b1, 3'd3, 15'o12345, 1'b0, 3'd0, 15'd0, 1'b1);
    drainAll("firstWrite", 10);

    // Writeback-to-decode bypass on channel 5.
    IO_read_sel   = 3'd5;
    IO_write_en   = 1'b1;
    IO_write_sel  = 3'd5;
    IO_write_data = 15'o07777;
    sbQueue.push_back({3'd5, 15'o07777});
    #1;
`ifdef IO_CHANNEL_BYPASS_EN
    checkOutput("bypassSameCycle", IO_read_data, 15'o07777);
`else
    checkOutput("bypassSameCycle", IO_read_data, 15'd0);
`endif
    tick();
    IO_write_en = 1'b0;
    #1;
    checkOutput("bypassNextCycle", IO_read_data, 15'o07777);
    drainAll("bypass", 10);

    // Fill a depth-4 FIFO, then overflow it with a fifth write.
    outIf.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'(i), 15'(i + 1), 1'b0, 3'd0, 15'd0, (i < 4));
      if (i == 3) checkOutput("fillNoOverflow", overflow, 1'b0);
    end
    checkOutput("fillOverflow", overflow, 1'b1);
    IO_read_sel = 3'd4;
    #1;
    checkOutput("droppedChannelUpdated", IO_read_data, 15'd5);
    drainAll("fill", 10);
    checkOutput("overflowSticky", overflow, 1'b1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("overflowCleared", overflow, 1'b0);

    // Full FIFO: a push paired with a pop is accepted without overflow.
    outIf.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 3'(i), 15'(8 + i), 1'b0, 3'd0, 15'd0, 1'b1);
    outIf.out_ready = 1'b1;
    applyStimulus(1'b1, 3'd6, 15'o77, 1'b0, 3'd0, 15'd0, 1'b1);
    checkOutput("pushPopNoOverflow", overflow, 1'b0);
    outIf.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd7, 15'd1, 1'b0, 3'd0, 15'd0, 1'b0);
    checkOutput("stillFullOverflow", overflow, 1'b1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    drainAll("pushPop", 10);

    // Collision on channel 2: the core write wins.
    applyStimulus(1'b1, 3'd2, 15'o111, 1'b1, 3'd2, 15'o222, 1'b1);
    IO_read_sel = 3'd2;
    #1;
    checkOutput("collisionCoreWins", IO_read_data, 15'o111);
    drainAll("collision", 10);

    // Peripheral load on channel 1: no bypass and no FIFO entry.
    IO_read_sel  = 3'd1;
    ext_in_valid = 1'b1;
    ext_in_sel   = 3'd1;
    ext_in_data  = 15'o333;
    #1;
    checkOutput("extNoBypass", IO_read_data, 15'd9);
    tick();
    ext_in_valid = 1'b0;
    checkOutput("extLoadVisible", IO_read_data, 15'o333);
    tick();
    checkOutput("extNoFifoEntry", outIf.out_valid, 1'b0);

    // Pointer wrap: 20 writes with out_ready toggling 1,0,1,0...
    for (int i = 0; i < 20; i++) begin
      outIf.out_ready = 1'b1;
      applyStimulus(1'b1, 3'(i % 8), 15'(i * 37 + 5), 1'b0, 3'd0, 15'd0, 1'b1);
      outIf.out_ready = 1'b0;
      tick();
    end
    drainAll("wrap", 20);
    checkOutput("wrapNoOverflow", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
